// File: rtl/mvm_ctrl.sv
// mvm_ctrl: control sequencer for the crossbar MVM datapath.
// Walks every input row, skipping the read/calc/sum phases for zero activations.
module mvm_ctrl #(
   parameter int XBAR_SIZE = 16,
   parameter int CNT_BITS  = $clog2(XBAR_SIZE)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                prog_req,
   input  logic                skip,
   output logic                get_ready,
   output logic                fetch,
   output logic                rd_en,
   output logic                calc,
   output logic                up_sum,
   output logic                prog_wt,
   output logic [CNT_BITS-1:0] counter,
   output logic                mvm_done,
   output logic                busy,
   output logic [CNT_BITS:0]   skip_cnt
);
   typedef enum logic [2:0] {IDLE, PROG, READY, FETCH, READ, CALC, UPSUM, DONE} state_t;
   state_t              r_state, w_next;
   logic [CNT_BITS-1:0] r_counter;
   logic [CNT_BITS:0]   r_skip_cnt;
   logic                w_last;
   assign w_last = r_counter == CNT_BITS'(XBAR_SIZE - 1);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = prog_req ? PROG : start ? READY : IDLE;
         PROG:    w_next = IDLE;
         READY:   w_next = FETCH;
         FETCH:   w_next = !skip ? READ : w_last ? DONE : FETCH;
         READ:    w_next = CALC;
         CALC:    w_next = UPSUM;
         UPSUM:   w_next = w_last ? DONE : FETCH;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_counter  <= '0;
         r_skip_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == READY) r_skip_cnt <= '0;
         else if (r_state == FETCH && skip) r_skip_cnt <= r_skip_cnt + 1'b1;
         // counter saturates at the last row; DONE/READY re-arm it for the next MVM
         if (r_state == READY || r_state == DONE) r_counter <= '0;
         else if (((r_state == FETCH && skip) || r_state == UPSUM) && !w_last) r_counter <= r_counter + 1'b1;
      end
   end
   assign prog_wt   = r_state == PROG;
   assign get_ready = r_state == READY;
   assign fetch     = r_state == FETCH;
   assign rd_en     = r_state == READ;
   assign calc      = r_state == CALC;
   assign up_sum    = r_state == UPSUM;
   assign mvm_done  = r_state == DONE;
   assign busy      = r_state != IDLE;
   assign counter   = r_counter;
   assign skip_cnt  = r_skip_cnt;
endmodule

// File: tb/tb_mvm_ctrl.sv
// tb_mvm_ctrl: randomized self-checking bench for mvm_ctrl.
// Expected per-cycle control traces are built from the row skip pattern.
module tb_mvm_ctrl;
   localparam int N  = 16;
   localparam int CB = $clog2(N);
   localparam logic [6:0] C_PROG  = 7'b1000000, C_READY = 7'b0100000, C_FETCH = 7'b0010000,
                          C_READ  = 7'b0001000, C_CALC  = 7'b0000100, C_UPSUM = 7'b0000010,
                          C_DONE  = 7'b0000001;
   logic clk = 0, reset = 1, start = 0, prog_req = 0, skip_noise = 0;
   logic [N-1:0] mask = '0;
   logic get_ready, fetch, rd_en, calc, up_sum, prog_wt, mvm_done, busy, skip;
   logic [CB-1:0] counter;
   logic [CB:0] skip_cnt;
   int vectors = 0, errors = 0;
   wire [6:0] ctl = {prog_wt, get_ready, fetch, rd_en, calc, up_sum, mvm_done};
   // skip only means something during fetch; elsewhere it carries noise
   assign skip = fetch ? mask[counter] : skip_noise;
   always #5 clk = ~clk;
   mvm_ctrl #(.XBAR_SIZE(N)) dut (
      .clk(clk), .reset(reset), .start(start), .prog_req(prog_req), .skip(skip),
      .get_ready(get_ready), .fetch(fetch), .rd_en(rd_en), .calc(calc), .up_sum(up_sum),
      .prog_wt(prog_wt), .counter(counter), .mvm_done(mvm_done), .busy(busy), .skip_cnt(skip_cnt)
   );
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_idle(input string name, input int exp_skips);
      vectors++;
      if (ctl !== 7'b0 || busy !== 1'b0 || counter !== '0 || skip_cnt !== (CB+1)'(exp_skips)) begin
         errors++;
         $display("FAIL %s: ctl=%b busy=%b counter=%0d skip_cnt=%0d, expected ctl=0 busy=0 counter=0 skip_cnt=%0d",
                  name, ctl, busy, counter, skip_cnt, exp_skips);
      end
   endtask

   task automatic run_mvm(input logic [N-1:0] m, input bit noise, output int done_cyc);
      logic [6:0] eq[$];
      int rq[$];
      int ns = 0;
      eq.push_back(C_READY); rq.push_back(-1);
      for (int r = 0; r < N; r++) begin
         eq.push_back(C_FETCH); rq.push_back(r);
         if (m[r]) ns++;
         else begin
            eq.push_back(C_READ);  rq.push_back(r);
            eq.push_back(C_CALC);  rq.push_back(r);
            eq.push_back(C_UPSUM); rq.push_back(r);
         end
      end
      eq.push_back(C_DONE); rq.push_back(-1);
      done_cyc = -1;
      mask = m;
      @(negedge clk);
      start = 1; prog_req = 0;
      for (int i = 0; i < eq.size(); i++) begin
         @(negedge clk);
         vectors++;
         if (ctl !== eq[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL ctl cycle %0d: got ctl=%b busy=%b, expected ctl=%b busy=1", i + 1, ctl, busy, eq[i]);
         end
         if (rq[i] >= 0) begin
            vectors++;
            if (counter !== CB'(rq[i])) begin
               errors++;
               $display("FAIL counter cycle %0d: got %0d, expected %0d", i + 1, counter, rq[i]);
            end
         end
         if (eq[i] == C_DONE) begin
            vectors++;
            if (skip_cnt !== (CB+1)'(ns)) begin
               errors++;
               $display("FAIL skip_cnt at done: got %0d, expected %0d", skip_cnt, ns);
            end
         end
         if (mvm_done === 1'b1 && done_cyc < 0) done_cyc = i + 1;
         start      = (noise && i < eq.size() - 1) ? 1'($urandom % 2) : 1'b0;
         prog_req   = (noise && i < eq.size() - 1) ? 1'($urandom % 2) : 1'b0;
         skip_noise = 1'($urandom % 2);
      end
      @(negedge clk);
      check_idle("idle after mvm", ns);
   endtask

   task automatic check_done_cycle(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s done latency: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_idle("reset state", 0);
      reset = 0;
      repeat (2) @(negedge clk);
      check_idle("idle after reset", 0);
   endtask

   task automatic test_prog();
      prog_req = 1;
      @(negedge clk);
      prog_req = 0;
      vectors++;
      if (ctl !== C_PROG || busy !== 1'b1) begin
         errors++;
         $display("FAIL prog: ctl=%b busy=%b, expected ctl=%b busy=1", ctl, busy, C_PROG);
      end
      @(negedge clk);
      check_idle("after prog", 0);
   endtask

   task automatic test_priority();
      start = 1; prog_req = 1;
      @(negedge clk);
      start = 0; prog_req = 0;
      vectors++;
      if (ctl !== C_PROG) begin
         errors++;
         $display("FAIL priority: ctl=%b, expected %b", ctl, C_PROG);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("no mvm after prog priority", 0);
      end
   endtask

   task automatic test_directed();
      int d;
      run_mvm('0, 1'b0, d);
      check_done_cycle("no skip", d, 66);
      run_mvm(N'(16'h0088), 1'b1, d);
      check_done_cycle("rows 3,7 skipped", d, 60);
      run_mvm('1, 1'b1, d);
      check_done_cycle("all skipped", d, 18);
   endtask

   task automatic test_random();
      int d, exp;
      logic [N-1:0] m;
      for (int k = 0; k < 8; k++) begin
         m = (k % 2) ? N'($urandom) : N'($urandom & $urandom);
         exp = 2;
         for (int r = 0; r < N; r++) exp += m[r] ? 1 : 4;
         run_mvm(m, 1'b1, d);
         check_done_cycle("random", d, exp);
      end
   endtask

   task automatic test_abort();
      int d;
      bit found = 0, saw_done = 0;
      mask = '0;
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (calc === 1'b1 && counter === CB'(5)) found = 1;
      end
      vectors++;
      if (!found) begin
         errors++;
         $display("FAIL abort: never reached calc at row 5, got counter=%0d", counter);
      end
      @(posedge clk);
      #2 reset = 1;
      #1 vectors++;
      if (ctl !== 7'b0 || busy !== 1'b0 || counter !== '0) begin
         errors++;
         $display("FAIL async reset: ctl=%b busy=%b counter=%0d, expected all 0", ctl, busy, counter);
      end
      repeat (2) begin
         @(negedge clk);
         if (mvm_done === 1'b1) saw_done = 1;
      end
      reset = 0;
      repeat (3) begin
         @(negedge clk);
         if (mvm_done === 1'b1) saw_done = 1;
      end
      vectors++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort: mvm_done=1 seen after reset, expected 0");
      end
      run_mvm('0, 1'b0, d);
      check_done_cycle("after abort", d, 66);
   endtask

   initial begin
      test_reset();
      test_prog();
      test_priority();
      test_directed();
      test_random();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
